// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory port between the
// instruction-fetch requester (I, read-only) and the load/store requester
// (D, read or byte-masked write). One transaction in flight at a time; the
// fixed memory read latency is counted and the read word is captured into a
// per-requester data register before a one-cycle ack goes to the winner.
//
// Build option: define ARB_DPRIO_EN for fixed priority (D wins every tie).
// Left undefined, ties are resolved round-robin against the last grant.
//
// state | meaning
// IDLE  | no transaction; arbitrate and register address/data on a request
// ISSUE | memory strobe (read or write) is high for this single cycle
// WAIT  | counting LATENCY cycles; read data captured when cnt reaches 1
// ACK   | one-cycle ack to the winner; no new grant while its req is high
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t     state;
    logic       gnt_d;
    logic       is_write;
    logic [2:0] cnt;
    logic       pick_d;
    logic       start_write;

`ifdef ARB_DPRIO_EN
    // Fixed priority: the load/store side wins whenever it is requesting.
    always_comb begin
        pick_d = d_req;
    end
`else
    logic last_grant_d;

    // Round-robin: on a tie, grant the requester that did not win last time.
    always_comb begin
        pick_d = d_req && (!i_req || !last_grant_d);
    end
`endif

    // A write is a D grant with at least one byte enable set.
    always_comb begin
        start_write = pick_d && (d_wmask != 4'b0000);
    end

    // Sequencer: all outputs are registered and change on state transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            is_write  <= 1'b0;
            cnt       <= 3'd0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= 32'h0;
            d_rdata   <= 32'h0;
            mem_addr  <= '0;
            mem_rstrb <= 1'b0;
            mem_wmask <= 4'b0000;
            mem_wdata <= 32'h0;
            busy      <= 1'b0;
`ifndef ARB_DPRIO_EN
            last_grant_d <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        gnt_d     <= pick_d;
                        is_write  <= start_write;
                        mem_addr  <= pick_d ? d_addr : i_addr;
                        if (pick_d) begin
                            mem_wdata <= d_wdata;
                        end
                        // Strobes are set here so they are high during ISSUE.
                        mem_rstrb <= !start_write;
                        mem_wmask <= start_write ? d_wmask : 4'b0000;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_rstrb <= 1'b0;
                    mem_wmask <= 4'b0000;
                    cnt       <= 3'(LATENCY);
                    state     <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (!is_write) begin
                            if (gnt_d) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                i_rdata <= mem_rdata;
                            end
                        end
                        i_ack <= !gnt_d;
                        d_ack <= gnt_d;
                        state <= ACK;
                    end
                end
                ACK: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
`ifndef ARB_DPRIO_EN
                    last_grant_d <= gnt_d;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed cases followed by randomized
// traffic from two independent requesters. A transaction-level reference
// model (one transaction occupies LAT+3 cycles from its grant) predicts every
// strobe and ack; a monitor pops and compares whenever the DUT presents one.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int LAT = 3;
    localparam int TMO = 300;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic [3:0]    d_wmask;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rstrb;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;

    mem_port_arbiter #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wmask   (d_wmask),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [3:0]    wmask;
        logic [31:0]   wdata;
        int unsigned   stb_cyc;
        int unsigned   ack_cyc;
        logic [31:0]   exp_i;
        logic [31:0]   exp_d;
    } txn_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } rd_t;

    txn_t        stb_q[$];
    txn_t        ack_q[$];
    rd_t         rd_q[$];
    logic [31:0] ref_mem [64];
    logic [31:0] dev_mem [64];
    int unsigned cyc = 0;
    int unsigned next_free = 0;
    int unsigned busy_lo = 1;
    int unsigned busy_hi = 0;
    bit          ref_last_d = 1'b1;
    logic [31:0] ref_i = 32'h0;
    logic [31:0] ref_d = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_i_ack"},     64'(i_ack),     64'h0);
        check({tag, "_d_ack"},     64'(d_ack),     64'h0);
        check({tag, "_i_rdata"},   64'(i_rdata),   64'h0);
        check({tag, "_d_rdata"},   64'(d_rdata),   64'h0);
        check({tag, "_mem_addr"},  64'(mem_addr),  64'h0);
        check({tag, "_mem_rstrb"}, 64'(mem_rstrb), 64'h0);
        check({tag, "_mem_wmask"}, 64'(mem_wmask), 64'h0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'h0);
        check({tag, "_busy"},      64'(busy),      64'h0);
    endtask

    task automatic mem_init();
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[4]  = 32'h0000_0013;
        dev_mem[4]  = 32'h0000_0013;
        ref_mem[16] = 32'hCAFE_0001;
        dev_mem[16] = 32'hCAFE_0001;
    endtask

    // Reference model, evaluated at the rising edge that ends cycle 'cyc'.
    task automatic model_step();
        int unsigned cur = cyc;
        txn_t        t;
        bit          win_d;
        int          idx;
        if (reset) begin
            stb_q.delete();
            ack_q.delete();
            rd_q.delete();
            next_free  = cur + 1;
            ref_last_d = 1'b1;
            ref_i      = 32'h0;
            ref_d      = 32'h0;
            busy_lo    = 1;
            busy_hi    = 0;
            mem_init();
        end else if (cur >= next_free && (i_req || d_req)) begin
            if (i_req && d_req) begin
`ifdef ARB_DPRIO_EN
                win_d = 1'b1;
`else
                win_d = !ref_last_d;
`endif
            end else begin
                win_d = d_req;
            end
            t.is_d  = win_d;
            t.addr  = win_d ? d_addr : i_addr;
            t.wr    = win_d && (d_wmask != 4'b0000);
            t.wmask = t.wr ? d_wmask : 4'b0000;
            t.wdata = d_wdata;
            idx = int'(t.addr[7:2]);
            if (t.wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (t.wmask[b]) ref_mem[idx][8*b +: 8] = t.wdata[8*b +: 8];
                end
            end else if (win_d) begin
                ref_d = ref_mem[idx];
            end else begin
                ref_i = ref_mem[idx];
            end
            t.exp_i   = ref_i;
            t.exp_d   = ref_d;
            t.stb_cyc = cur + 1;
            t.ack_cyc = cur + LAT + 2;
            busy_lo   = cur + 1;
            busy_hi   = cur + LAT + 2;
            next_free = cur + LAT + 3;
            ref_last_d = win_d;
            stb_q.push_back(t);
            ack_q.push_back(t);
        end
        // Memory read data is valid only in its one scheduled cycle.
        if (rd_q.size() > 0 && rd_q[0].cyc == cur + 1) begin
            mem_rdata <= rd_q[0].data;
            void'(rd_q.pop_front());
        end else begin
            mem_rdata <= $urandom;
        end
        cyc = cur + 1;
    endtask

    // Monitor plus memory device, evaluated mid-cycle.
    task automatic monitor_step();
        txn_t t;
        int   idx;
        if (cyc == 0) return;
        if (reset) begin
            check_zero("rst_hold");
            return;
        end
        check("ack_excl", 64'(i_ack & d_ack), 64'h0);
        check("strobe_excl", 64'(mem_rstrb && (mem_wmask != 4'b0000)), 64'h0);
        check("busy", 64'(busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
        idx = int'(mem_addr[7:2]);
        if (mem_rstrb || mem_wmask != 4'b0000) begin
            if (stb_q.size() == 0) begin
                flag("unexpected_strobe");
            end else begin
                t = stb_q.pop_front();
                check("strobe_cycle", 64'(cyc), 64'(t.stb_cyc));
                check("mem_addr", 64'(mem_addr), 64'(t.addr));
                check("mem_rstrb", 64'(mem_rstrb), 64'(!t.wr));
                check("mem_wmask", 64'(mem_wmask), 64'(t.wmask));
                if (t.wr) check("mem_wdata", 64'(mem_wdata), 64'(t.wdata));
            end
            if (mem_rstrb) begin
                rd_q.push_back('{cyc + LAT, dev_mem[idx]});
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask[b]) dev_mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end
        end else if (stb_q.size() > 0 && stb_q[0].stb_cyc <= cyc) begin
            flag("missing_strobe");
            void'(stb_q.pop_front());
        end
        if (i_ack || d_ack) begin
            if (ack_q.size() == 0) begin
                flag("unexpected_ack");
            end else begin
                t = ack_q.pop_front();
                check("ack_cycle", 64'(cyc), 64'(t.ack_cyc));
                check("i_ack", 64'(i_ack), 64'(!t.is_d));
                check("d_ack", 64'(d_ack), 64'(t.is_d));
                check("i_rdata", 64'(i_rdata), 64'(t.exp_i));
                check("d_rdata", 64'(d_rdata), 64'(t.exp_d));
            end
        end else if (ack_q.size() > 0 && ack_q[0].ack_cyc <= cyc) begin
            flag("missing_ack");
            void'(ack_q.pop_front());
        end
    endtask

    task automatic i_txn(input logic [AW-1:0] a);
        bit got = 1'b0;
        i_addr = a;
        i_req  = 1'b1;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (i_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) flag("i_ack_timeout");
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    task automatic d_txn(input logic [AW-1:0] a, input logic [3:0] m, input logic [31:0] w);
        bit got = 1'b0;
        d_addr  = a;
        d_wmask = m;
        d_wdata = w;
        d_req   = 1'b1;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (d_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) flag("d_ack_timeout");
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'(($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2));
    endfunction

    task automatic gap();
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        i_req     = 1'b0;
        d_req     = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_wmask   = 4'b0000;
        d_wdata   = 32'h0;
        mem_rdata = 32'h0;
        fork
            forever begin
                @(clk);
                if (clk === 1'b1) model_step();
                else if (clk === 1'b0) monitor_step();
            end
        join_none

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero("reset_state");

        @(posedge clk);
        #1;
        i_txn(32'h0000_0010);
        d_txn(32'h0000_0020, 4'b0011, 32'hDEAD_BEEF);
        d_txn(32'h0000_0040, 4'b0000, 32'h0);
        fork
            i_txn(32'h0000_0008);
            d_txn(32'h0000_000C, 4'b0000, 32'h0);
        join
        fork
            i_txn(32'h0000_0014);
            d_txn(32'h0000_0018, 4'b1111, 32'h1234_5678);
        join
        fork
            d_txn(32'h0000_0044, 4'b0000, 32'h0);
            begin
                repeat (LAT + 2) @(posedge clk);
                #1;
                i_txn(32'h0000_0048);
            end
        join

        // Reset while a fetch is in WAIT: everything clears, no ack follows.
        i_addr = 32'h0000_0010;
        i_req  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_req = 1'b0;
        #1;
        check_zero("reset_async");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        fork
            i_txn(32'h0000_0010);
            d_txn(32'h0000_0024, 4'b0000, 32'h0);
        join

        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    i_txn(rand_addr());
                    gap();
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    if ($urandom_range(0, 1) == 1)
                        d_txn(rand_addr(), 4'($urandom_range(1, 15)), $urandom);
                    else
                        d_txn(rand_addr(), 4'b0000, 32'h0);
                    gap();
                end
            end
        join

        repeat (LAT + 6) @(posedge clk);
        @(negedge clk);
        check("sb_drain", 64'(stb_q.size() + ack_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous-read memory port of the core between two requesters: instruction fetch (I, read-only) and load/store (D, read or byte-masked write).
- Sits between the core state machine and the MEM array.
- Grants one transaction at a time, drives the memory strobes, counts the fixed read latency, captures read data and returns a one-cycle ack to the winner.
- Ties are round-robin by default.

Parameters:
- ADDR_W, 32, byte-address width of requesters and memory port
- LATENCY, 1, cycles from strobe cycle to valid mem_rdata; legal range 1..7

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  ADDR_W  fetch byte address; stable while i_req
- i_ack  out  1  one-cycle pulse; i_rdata valid from this cycle
- i_rdata  out  32  fetched word (registered)
- d_req  in  1  load/store request; held until d_ack
- d_addr  in  ADDR_W  load/store byte address; stable while d_req
- d_wmask  in  4  byte write enables; 0 = read
- d_wdata  in  32  store data; stable while d_req
- d_ack  out  1  one-cycle pulse
- d_rdata  out  32  loaded word (registered; updated on reads only)
- mem_addr  out  ADDR_W  registered address to memory
- mem_rstrb  out  1  read strobe, high exactly one cycle per read
- mem_wmask  out  4  write byte enables, non-zero exactly one cycle per write
- mem_wdata  out  32  registered store data
- mem_rdata  in  32  memory read data, valid LATENCY cycles after strobe cycle
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, i_rdata=d_rdata=0, last_grant=D. An in-flight transaction is dropped with no ack. The requester is expected to re-request.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - No request: stay.
  - Request present: choose winner, register mem_addr and mem_wdata (D only), gnt_d, is_write (gnt_d && d_wmask!=0); go to ISSUE.
- ISSUE (1 cycle):
  - mem_rstrb = !is_write.
  - mem_wmask = is_write ? d_wmask : 0.
  - Load cnt=LATENCY; go to WAIT.
- WAIT (LATENCY cycles):
  - Decrement cnt.
  - In the cycle where cnt==1: at the clock edge, capture mem_rdata into i_rdata (I read) or d_rdata (D read); writes capture nothing. Go to ACK.
- ACK (1 cycle):
  - Assert i_ack or d_ack for the winner; update last_grant.
  - No new grant is made in ACK, because the winner's req is still high this cycle.
  - Go to IDLE.
- Latency: request first seen in IDLE cycle 0 → strobe in cycle 1 → ack in cycle LATENCY+2. Back-to-back throughput is one transaction per LATENCY+3 cycles.
- Arbitration: only one of i_req, d_req high → grant it. Both high in the same IDLE cycle → grant the one that is not last_grant. First tie after reset goes to I.
- Request dropped before ack: protocol violation. The arbiter completes the transaction and still pulses ack.
- mem_addr and mem_wdata hold their values outside ISSUE. Only the strobes are qualified.
- mem_rstrb and mem_wmask are never both non-zero.
- i_ack and d_ack are never high together.

Optional Feature:
- ARB_DPRIO_EN
  - Defined: fixed priority; D always wins a tie; last_grant unused.
  - Undefined: round-robin as above.
  - Latency and handshakes are identical in both builds.

Test Plan:
- LATENCY=1, single fetch i_addr=0x10, mem returns 0x00000013 → mem_rstrb in cycle 1 with mem_addr=0x10; i_ack in cycle 3 with i_rdata=0x00000013; busy high in cycles 1-3.
- Store d_addr=0x20, d_wmask=4'b0011, d_wdata=0xDEADBEEF → mem_wmask=0011 for exactly one cycle, mem_rstrb stays 0; d_ack in cycle 3; d_rdata unchanged.
- i_req and d_req both held continuously, each re-asserted the cycle after its ack → grants I,D,I,D. With ARB_DPRIO_EN: D,D,D…, I starves while d_req is held.
- LATENCY=3, load d_addr=0x40, mem_rdata valid only in the 3rd cycle after the strobe = 0xCAFE0001 → d_ack 5 cycles after request; d_rdata=0xCAFE0001.
- Reset pulsed during WAIT of a fetch → all outputs 0 immediately; no i_ack; next i_req serviced normally with i_ack at cycle LATENCY+2.
- Request arriving during ACK of the other requester → not granted until the next IDLE cycle; its strobe appears 2 cycles after the first ack.
